// File: rtl/md_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per clock; sign fix-up and HI/LO write happen in FIX.
module md_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               is_div, is_signed, a_neg, sign_diff, b_zero;
  logic [WIDTH-1:0]   a_raw, opnd;
  logic [2*WIDTH-1:0] prod, prod_nxt, prod_fix;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic [WIDTH:0]     add_sum, div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return -v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return -v;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic sgn);
    return (sgn && v[WIDTH-1]) ? neg_w(v) : v;
  endfunction

  assign a_s   = A;
  assign b_s   = B;
  assign a_mag = magnitude(a_s, op[1]);
  assign b_mag = magnitude(b_s, op[1]);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (cnt == LAST_ITER) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy   = (state != S_IDLE);
    accept = (state == S_IDLE) && start;
  end

  // One iteration: multiplier/quotient bits live in the low half of prod
  always_comb begin
    add_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
    div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
    prod_nxt  = is_div ? {div_rem, prod[WIDTH-2:0], div_ge}
                       : {add_sum, prod[WIDTH-1:1]};
  end

  // Sign fix-up of the magnitude result
  always_comb begin
    prod_fix = (is_signed && sign_diff) ? neg_2w(prod) : prod;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (b_zero) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_lo = (is_signed && sign_diff) ? neg_w(prod[WIDTH-1:0]) : prod[WIDTH-1:0];
        res_hi = a_neg ? neg_w(prod[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Control and architectural registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= (state == S_FIX);
      if (accept)                cnt <= '0;
      else if (state == S_CALC)  cnt <= cnt + CNT_W'(1);
      if (accept)                div_by_zero <= 1'b0;
      else if (state == S_FIX)   div_by_zero <= is_div && b_zero;
      if (state == S_FIX) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == S_IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div    <= op[0];
      is_signed <= op[1];
      a_neg     <= op[1] && a_s[WIDTH-1];
      sign_diff <= a_s[WIDTH-1] ^ b_s[WIDTH-1];
      b_zero    <= (B == '0);
      a_raw     <= A;
      opnd      <= op[0] ? b_mag : a_mag;
      prod      <= {{WIDTH{1'b0}}, (op[0] ? a_mag : b_mag)};
    end else if (state == S_CALC) begin
      prod <= prod_nxt;
    end
  end

endmodule

// File: tb/tb_md_muldiv_unit.sv
// Self-checking bench for md_muldiv_unit: directed cases plus randomized ops
// against a plain-arithmetic model, on WIDTH=32 and WIDTH=8 instances.
module tb_md_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start32, hi_we32, lo_we32, busy32, done32, dbz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, wd32, hi32, lo32;
  logic        start8, hi_we8, lo_we8, busy8, done8, dbz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wd8, hi8, lo8;

  int chk_cnt = 0;
  int pass_cnt = 0;

  md_muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .A(a32), .B(b32),
    .hi_we(hi_we32), .lo_we(lo_we32), .wdata(wd32), .busy(busy32), .done(done32),
    .div_by_zero(dbz32), .hi(hi32), .lo(lo32));

  md_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .A(a8), .B(b8),
    .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wd8), .busy(busy8), .done(done8),
    .div_by_zero(dbz8), .hi(hi8), .lo(lo8));

  // Reference: MIPS HI/LO semantics computed with 64-bit integer arithmetic
  function automatic void model(input int w, input logic [1:0] o,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] mh, output logic [63:0] ml);
    logic [63:0] mask;
    longint sa, sb, pr, q, r;
    mask = (64'd1 << w) - 64'd1;
    sa = o[1] ? ($signed(a << (64 - w)) >>> (64 - w)) : $signed(a);
    sb = o[1] ? ($signed(b << (64 - w)) >>> (64 - w)) : $signed(b);
    if (!o[0]) begin
      pr = sa * sb;
      ml = pr & mask;
      mh = (pr >> w) & mask;
    end else if (b == 64'd0) begin
      mh = a & mask;
      ml = mask;
    end else if (o[1]) begin
      q = sa / sb;
      r = sa % sb;
      ml = q & mask;
      mh = r & mask;
    end else begin
      ml = (a / b) & mask;
      mh = (a % b) & mask;
    end
  endfunction

  task automatic op32_run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcyc, output logic [31:0] hi_e0);
    @(negedge clk);
    op32 = o; a32 = a; b32 = b; start32 = 1'b1;
    lat = -1; bcyc = 0; hi_e0 = 'x;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (n == 0) begin
        start32 = 1'b0; hi_we32 = 1'b0; lo_we32 = 1'b0;
        a32 = $urandom; b32 = $urandom; hi_e0 = hi32;
      end
      if (busy32) bcyc++;
      if (done32) begin lat = n; break; end
    end
  endtask

  task automatic op8_run(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int bcyc);
    @(negedge clk);
    op8 = o; a8 = a; b8 = b; start8 = 1'b1;
    lat = -1; bcyc = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (n == 0) begin start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); end
      if (busy8) bcyc++;
      if (done8) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start32 = 0; hi_we32 = 0; lo_we32 = 0; op32 = 0; a32 = 0; b32 = 0; wd32 = 0;
    start8 = 0; hi_we8 = 0; lo_we8 = 0; op8 = 0; a8 = 0; b8 = 0; wd8 = 0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (busy32 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy32); else pass_cnt++;
    chk_cnt++; if (done32 !== 1'b0) $display("FAIL reset_done: got %b want 0", done32); else pass_cnt++;
    chk_cnt++; if (dbz32 !== 1'b0) $display("FAIL reset_dbz: got %b want 0", dbz32); else pass_cnt++;
    chk_cnt++; if (hi32 !== 32'h0) $display("FAIL reset_hi: got %h want 0", hi32); else pass_cnt++;
    chk_cnt++; if (lo32 !== 32'h0) $display("FAIL reset_lo: got %h want 0", lo32); else pass_cnt++;
    chk_cnt++; if ({hi8, lo8, busy8} !== 17'h0) $display("FAIL reset_w8: got %h want 0", {hi8, lo8, busy8}); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int lat, bc; logic [31:0] he;
    op32_run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, he);
    chk_cnt++; if (hi32 !== 32'hFFFFFFFE) $display("FAIL multu_max_hi: got %h want fffffffe", hi32); else pass_cnt++;
    chk_cnt++; if (lo32 !== 32'h00000001) $display("FAIL multu_max_lo: got %h want 00000001", lo32); else pass_cnt++;
    chk_cnt++; if (lat !== 33) $display("FAIL multu_latency: got %0d want 33", lat); else pass_cnt++;
    chk_cnt++; if (bc !== 33) $display("FAIL multu_busy_cycles: got %0d want 33", bc); else pass_cnt++;
    op32_run(2'b10, 32'hFFFFFFFD, 32'd7, lat, bc, he);
    chk_cnt++; if (hi32 !== 32'hFFFFFFFF) $display("FAIL mult_neg_hi: got %h want ffffffff", hi32); else pass_cnt++;
    chk_cnt++; if (lo32 !== 32'hFFFFFFEB) $display("FAIL mult_neg_lo: got %h want ffffffeb", lo32); else pass_cnt++;
    op32_run(2'b10, 32'h80000000, 32'h80000000, lat, bc, he);
    chk_cnt++; if (hi32 !== 32'h40000000) $display("FAIL mult_min_hi: got %h want 40000000", hi32); else pass_cnt++;
    chk_cnt++; if (lo32 !== 32'h0) $display("FAIL mult_min_lo: got %h want 0", lo32); else pass_cnt++;
  endtask

  task automatic test_div();
    int lat, bc; logic [31:0] he;
    op32_run(2'b11, 32'hFFFFFFF9, 32'd2, lat, bc, he);
    chk_cnt++; if (lo32 !== 32'hFFFFFFFD) $display("FAIL div_neg_lo: got %h want fffffffd", lo32); else pass_cnt++;
    chk_cnt++; if (hi32 !== 32'hFFFFFFFF) $display("FAIL div_neg_hi: got %h want ffffffff", hi32); else pass_cnt++;
    op32_run(2'b01, 32'd100, 32'd7, lat, bc, he);
    chk_cnt++; if (lo32 !== 32'd14) $display("FAIL divu_lo: got %0d want 14", lo32); else pass_cnt++;
    chk_cnt++; if (hi32 !== 32'd2) $display("FAIL divu_hi: got %0d want 2", hi32); else pass_cnt++;
    chk_cnt++; if (lat !== 33) $display("FAIL divu_latency: got %0d want 33", lat); else pass_cnt++;
    op32_run(2'b11, 32'h80000000, 32'hFFFFFFFF, lat, bc, he);
    chk_cnt++; if (lo32 !== 32'h80000000) $display("FAIL div_min_lo: got %h want 80000000", lo32); else pass_cnt++;
    chk_cnt++; if (hi32 !== 32'h0) $display("FAIL div_min_hi: got %h want 0", hi32); else pass_cnt++;
  endtask

  task automatic test_div_zero();
    int lat, bc; logic [31:0] he;
    op32_run(2'b01, 32'h00001234, 32'h0, lat, bc, he);
    chk_cnt++; if (hi32 !== 32'h00001234) $display("FAIL dbz_hi: got %h want 00001234", hi32); else pass_cnt++;
    chk_cnt++; if (lo32 !== 32'hFFFFFFFF) $display("FAIL dbz_lo: got %h want ffffffff", lo32); else pass_cnt++;
    chk_cnt++; if (dbz32 !== 1'b1) $display("FAIL dbz_flag: got %b want 1", dbz32); else pass_cnt++;
    chk_cnt++; if (lat !== 33) $display("FAIL dbz_latency: got %0d want 33", lat); else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++; if (dbz32 !== 1'b1) $display("FAIL dbz_sticky: got %b want 1", dbz32); else pass_cnt++;
    op32 = 2'b00; a32 = 32'd5; b32 = 32'd6; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    chk_cnt++; if ({busy32, dbz32} !== 2'b10) $display("FAIL dbz_clear_on_start: got busy,dbz=%b want 10", {busy32, dbz32}); else pass_cnt++;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (done32) break;
    end
    chk_cnt++; if ({done32, lo32} !== {1'b1, 32'd30}) $display("FAIL dbz_next_op: got done=%b lo=%0d want done=1 lo=30", done32, lo32); else pass_cnt++;
  endtask

  task automatic test_random32();
    int lat, bc; logic [31:0] he, a, b; logic [1:0] o; logic [63:0] eh, el;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 7 == 3) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      if (i == 5) a = 32'h80000000;
      model(32, o, {32'h0, a}, {32'h0, b}, eh, el);
      op32_run(o, a, b, lat, bc, he);
      chk_cnt++; if (hi32 !== eh[31:0]) $display("FAIL rand32_hi op=%0d a=%h b=%h: got %h want %h", o, a, b, hi32, eh[31:0]); else pass_cnt++;
      chk_cnt++; if (lo32 !== el[31:0]) $display("FAIL rand32_lo op=%0d a=%h b=%h: got %h want %h", o, a, b, lo32, el[31:0]); else pass_cnt++;
      chk_cnt++; if (dbz32 !== (o[0] && b == 32'h0)) $display("FAIL rand32_dbz op=%0d b=%h: got %b", o, b, dbz32); else pass_cnt++;
      chk_cnt++; if (lat !== 33) $display("FAIL rand32_latency: got %0d want 33", lat); else pass_cnt++;
    end
  endtask

  task automatic test_idle_write();
    int lat, bc; logic [31:0] he;
    @(negedge clk); lo_we32 = 1'b1; wd32 = 32'h55;
    @(negedge clk); lo_we32 = 1'b0;
    chk_cnt++; if (lo32 !== 32'h55) $display("FAIL mtlo: got %h want 55", lo32); else pass_cnt++;
    hi_we32 = 1'b1; wd32 = 32'h1234;
    @(negedge clk); hi_we32 = 1'b0;
    chk_cnt++; if (hi32 !== 32'h1234) $display("FAIL mthi: got %h want 1234", hi32); else pass_cnt++;
    hi_we32 = 1'b1; wd32 = 32'h7777;
    op32_run(2'b01, 32'd1000, 32'd7, lat, bc, he);
    chk_cnt++; if (he !== 32'h7777) $display("FAIL start_mthi_same_cycle: got %h want 7777", he); else pass_cnt++;
    chk_cnt++; if ({hi32, lo32} !== {32'd6, 32'd142}) $display("FAIL start_mthi_result: got %h,%h want 6,142", hi32, lo32); else pass_cnt++;
  endtask

  task automatic test_collision();
    logic [31:0] old_hi; logic [63:0] eh, el; int lat;
    old_hi = hi32; lat = -1;
    model(32, 2'b10, 64'h00000000FFFFFFFB, 64'd9, eh, el);
    @(negedge clk); op32 = 2'b10; a32 = 32'hFFFFFFFB; b32 = 32'd9; start32 = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (n == 0) start32 = 1'b0;
      if (n == 4) begin start32 = 1'b1; hi_we32 = 1'b1; lo_we32 = 1'b1; wd32 = 32'hAAAA; a32 = $urandom; end
      if (n == 5) begin start32 = 1'b0; hi_we32 = 1'b0; lo_we32 = 1'b0; end
      if (n == 7) begin
        chk_cnt++; if (hi32 !== old_hi) $display("FAIL busy_hi_stale: got %h want %h", hi32, old_hi); else pass_cnt++;
      end
      if (done32) begin lat = n; break; end
    end
    chk_cnt++; if (lat !== 33) $display("FAIL collision_latency: got %0d want 33", lat); else pass_cnt++;
    chk_cnt++; if (hi32 !== eh[31:0]) $display("FAIL collision_hi: got %h want %h", hi32, eh[31:0]); else pass_cnt++;
    chk_cnt++; if (lo32 !== el[31:0]) $display("FAIL collision_lo: got %h want %h", lo32, el[31:0]); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if ({busy32, done32} !== 2'b00) $display("FAIL collision_no_relaunch: got busy,done=%b want 00", {busy32, done32}); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int lat, bc, done_seen; logic [31:0] he; logic [63:0] eh, el;
    done_seen = 0;
    @(negedge clk); op32 = 2'b11; a32 = 32'h00ABCDEF; b32 = 32'd13; start32 = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (n == 0) start32 = 1'b0;
      if (n == 9) reset = 1'b0;
      if (n == 10) begin
        reset = 1'b1;
        chk_cnt++; if (busy32 !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy32); else pass_cnt++;
        chk_cnt++; if ({hi32, lo32} !== 64'h0) $display("FAIL abort_hilo: got %h,%h want 0,0", hi32, lo32); else pass_cnt++;
      end
      if (done32) done_seen++;
    end
    chk_cnt++; if (done_seen !== 0) $display("FAIL abort_no_done: got %0d done pulses want 0", done_seen); else pass_cnt++;
    model(32, 2'b11, 64'h0000000000ABCDEF, 64'd13, eh, el);
    op32_run(2'b11, 32'h00ABCDEF, 32'd13, lat, bc, he);
    chk_cnt++; if ({hi32, lo32} !== {eh[31:0], el[31:0]}) $display("FAIL abort_then_op: got %h,%h want %h,%h", hi32, lo32, eh[31:0], el[31:0]); else pass_cnt++;
    chk_cnt++; if (lat !== 33) $display("FAIL abort_then_latency: got %0d want 33", lat); else pass_cnt++;
  endtask

  task automatic test_width8();
    int lat, bc; logic [7:0] a, b; logic [1:0] o; logic [63:0] eh, el;
    op8_run(2'b10, 8'h80, 8'h80, lat, bc);
    chk_cnt++; if ({hi8, lo8} !== 16'h4000) $display("FAIL w8_mult_min: got %h,%h want 40,00", hi8, lo8); else pass_cnt++;
    chk_cnt++; if (lat !== 9) $display("FAIL w8_latency: got %0d want 9", lat); else pass_cnt++;
    chk_cnt++; if (bc !== 9) $display("FAIL w8_busy_cycles: got %0d want 9", bc); else pass_cnt++;
    op8_run(2'b01, 8'd200, 8'd3, lat, bc);
    chk_cnt++; if (lo8 !== 8'd66) $display("FAIL w8_divu_lo: got %0d want 66", lo8); else pass_cnt++;
    chk_cnt++; if (hi8 !== 8'd2) $display("FAIL w8_divu_hi: got %0d want 2", hi8); else pass_cnt++;
    for (int i = 0; i < 25; i++) begin
      o = 2'($urandom_range(0, 3));
      a = 8'($urandom);
      b = (i % 6 == 2) ? 8'h0 : 8'($urandom);
      if (i == 4) begin o = 2'b11; a = 8'h80; b = 8'hFF; end
      model(8, o, {56'h0, a}, {56'h0, b}, eh, el);
      op8_run(o, a, b, lat, bc);
      chk_cnt++; if ({hi8, lo8} !== {eh[7:0], el[7:0]}) $display("FAIL rand8 op=%0d a=%h b=%h: got %h,%h want %h,%h", o, a, b, hi8, lo8, eh[7:0], el[7:0]); else pass_cnt++;
      chk_cnt++; if (dbz8 !== (o[0] && b == 8'h0)) $display("FAIL rand8_dbz op=%0d b=%h: got %b", o, b, dbz8); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_random32();
    test_idle_write();
    test_collision();
    test_reset_abort();
    test_width8();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
